fifo_word_packer: RTL and testbench
===================================

Name: fifo_word_packer

Overview:
Drains the byte FIFO on the read side and packs consecutive bytes into BYTES_PER_WORD-byte words, presented with a valid/ready handshake. It sits directly downstream of the FIFO read port and runs in the FIFO read-clock domain. It supports an explicit flush of a partially filled word.

Parameters:
BYTES_PER_WORD, 4, bytes per packed word (2..8)
RD_LATENCY, 1, cycles from the edge sampling fifo_rd high to the edge at which fifo_data holds that byte (1 or 2)
TIMEOUT_CYCLES, 16, idle-empty cycles before auto-flush (used only with the optional feature)

Ports:
clk  input  1  read-side clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_rd  output  1  FIFO read enable; single-cycle pulse per byte
fifo_data  input  8  FIFO data_out
flush  input  1  emit the partial word now
word_out  output  8*BYTES_PER_WORD  packed word; first byte read in bits [7:0] (little-endian)
word_bytes  output  $clog2(BYTES_PER_WORD+1)  number of valid bytes in word_out
word_valid  output  1  word_out/word_bytes valid
word_ready  input  1  consumer accepts word when word_valid && word_ready

Behaviour:
- Reset (asynchronous, active-high; exits on the first clk edge after deassert):
  - fifo_rd=0, word_valid=0, word_out=0, word_bytes=0; byte index=0; state FILL.
  - Reset mid-operation discards any in-flight byte and any partial word, with no output.
- States FILL, WAIT, HOLD:
  - FILL: if byte index < BYTES_PER_WORD and !fifo_empty, drive fifo_rd=1 for one cycle and go to WAIT.
    - fifo_rd is never high while fifo_empty is high, in WAIT, or in HOLD.
    - At most one read is in flight.
  - WAIT: count RD_LATENCY edges, then capture fifo_data into byte lane [byte index] of word_out and increment the index.
    - Index reaches BYTES_PER_WORD -> HOLD with word_bytes=BYTES_PER_WORD.
    - Otherwise -> FILL.
  - HOLD: word_valid=1.
    - word_out and word_bytes stay stable until word_valid && word_ready at a clk edge.
    - On that edge: word_valid=0, word_out cleared to 0, index=0, word_bytes=0, next state FILL.
    - The earliest following fifo_rd is the next cycle.
- Flush:
  - Sampled in FILL with index>0 (takes priority over issuing a read that cycle) -> HOLD with word_bytes=index. Unfilled lanes read 0.
  - Sampled in FILL with index=0: ignored; no empty word is ever emitted.
  - Sampled in WAIT: latched into a sticky flag. After the capture, go to HOLD with word_bytes=index (or full, if the capture completed the word). Flag cleared.
  - Sampled in HOLD: ignored.
- Throughput: one byte per RD_LATENCY+1 cycles. No double buffering, so FIFO reads stall while in HOLD.
- word_ready high with word_valid low has no effect.

Optional Feature:
- Macro FIFO_WORD_PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter increments each cycle that the state is FILL, index>0, and fifo_empty=1.
  - It resets to 0 on any capture, on a handshake, on reset, or whenever fifo_empty=0.
  - When it reaches TIMEOUT_CYCLES, perform an auto-flush identical to flush.
- Undefined: no counter is present, and partial words leave only through flush.

Test Plan:
1. Reset, then the FIFO holds 0x11,0x22,0x33,0x44 with word_ready=1 -> four fifo_rd pulses, each 2 cycles apart; word_out=0x44332211, word_bytes=4, word_valid high 1 cycle.
2. FIFO holds 0xA1,0xB2, fifo_empty rises, then flush pulses once -> word_out=0x0000B2A1, word_bytes=2; no fifo_rd while empty.
3. 8 bytes 0x01..0x08 with word_ready=0 for 10 cycles after the first word -> word_out=0x04030201 held stable, only 4 fifo_rd pulses before the handshake; the second word is 0x08070605.
4. flush asserted in the same cycle as the WAIT state for the 3rd byte 0xCC (bytes 0xAA,0xBB,0xCC) -> word_out=0x00CCBBAA, word_bytes=3.
5. Assert reset in WAIT after 2 bytes are captured -> all outputs 0 asynchronously; the next 4 bytes form a fresh word with no remnant of the old bytes.
6. With FIFO_WORD_PACKER_TIMEOUT_EN and TIMEOUT_CYCLES=16: 1 byte 0x5A, then empty -> word_valid rises 16 cycles after the capture, word_out=0x0000005A, word_bytes=1. Without the macro, word_valid stays 0.

Source files
------------

// File: rtl/fifo_word_packer_if.sv
// Interface bundling the FIFO read port and the packed-word output stream.
// master: the packer (drives fifo_rd and the word stream).
// slave:  the surrounding FIFO and consumer.
//
// Word handshake: word_out/word_bytes are valid while word_valid is high and
// stay stable until a clk edge sees word_valid && word_ready; that edge is the
// transfer. word_ready while word_valid is low does nothing.
interface fifo_word_packer_if #(
    parameter int BYTES_PER_WORD = 4
);
    localparam int BYTES_W = $clog2(BYTES_PER_WORD + 1);

    logic                          fifo_empty;
    logic                          fifo_rd;
    logic [7:0]                    fifo_data;
    logic                          flush;
    logic [8*BYTES_PER_WORD-1:0]   word_out;
    logic [BYTES_W-1:0]            word_bytes;
    logic                          word_valid;
    logic                          word_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  flush,
        input  word_ready,
        output fifo_rd,
        output word_out,
        output word_bytes,
        output word_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output flush,
        output word_ready,
        input  fifo_rd,
        input  word_out,
        input  word_bytes,
        input  word_valid
    );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains a byte FIFO and packs bytes little-endian into
// BYTES_PER_WORD-byte words presented on a valid/ready stream. A flush input
// emits a partially filled word. One read is in flight at a time, and reads
// stall while a finished word waits for the consumer.
//
// Optional build macro FIFO_WORD_PACKER_TIMEOUT_EN: adds an idle counter that
// auto-flushes a partial word after TIMEOUT_CYCLES empty cycles in FILL.
module fifo_word_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    fifo_word_packer_if.master        bus,
    output logic [1:0]                o_dbg_state
);
    localparam int                IDX_W    = $clog2(BYTES_PER_WORD + 1);
    localparam int                WORD_W   = 8 * BYTES_PER_WORD;
    localparam logic [IDX_W-1:0]  FULL_IDX = IDX_W'(BYTES_PER_WORD);
    localparam logic [1:0]        LAT_LAST = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_bytes;
    logic [WORD_W-1:0]   r_word;
    logic [1:0]          r_lat;
    logic                r_flush_pend;

    logic                w_lat_done;
    logic                w_capture;
    logic                w_capture_to_hold;
    logic                w_handshake;
    logic                w_auto_flush;
    logic                w_fill_flush;
    logic                w_issue_rd;
    logic [IDX_W-1:0]    w_idx_inc;

    assign w_idx_inc   = r_idx + IDX_W'(1);
    assign w_lat_done  = (r_lat == LAT_LAST);
    assign w_capture   = (r_state == S_WAIT) && w_lat_done;
    assign w_handshake = (r_state == S_HOLD) && bus.word_ready;

    // A flush seen at the capture edge counts the same as one latched earlier.
    assign w_capture_to_hold = w_capture &&
                               ((w_idx_inc == FULL_IDX) || r_flush_pend || bus.flush);

    // A flush of a non-empty partial word wins over starting another read.
    assign w_fill_flush = (r_state == S_FILL) && (r_idx != '0) &&
                          (bus.flush || w_auto_flush);

    assign w_issue_rd = (r_state == S_FILL) && !w_fill_flush &&
                        (r_idx < FULL_IDX) && !bus.fifo_empty;

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
    localparam int               IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle;
    logic              w_idle_cond;

    // Idle means a partial word is parked in FILL with nothing to read.
    assign w_idle_cond  = (r_state == S_FILL) && (r_idx != '0) && bus.fifo_empty;
    // The TIMEOUT_CYCLES-th consecutive idle cycle acts as a flush.
    assign w_auto_flush = w_idle_cond && (r_idle == IDLE_LAST);

    // Idle counter: runs only while idle, restarts on anything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
        end else if (!w_idle_cond || w_auto_flush) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end
`else
    assign w_auto_flush = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL: begin
                if (w_fill_flush) begin
                    w_next_state = S_HOLD;
                end else if (w_issue_rd) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_capture_to_hold) begin
                    w_next_state = S_HOLD;
                end else if (w_capture) begin
                    w_next_state = S_FILL;
                end
            end
            S_HOLD: begin
                if (bus.word_ready) begin
                    w_next_state = S_FILL;
                end
            end
            default: begin
                w_next_state = S_FILL;
            end
        endcase
    end

    // Read-latency counter and sticky flush seen while a read is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) && !w_lat_done) begin
                r_lat <= r_lat + 2'd1;
            end else begin
                r_lat <= '0;
            end
            r_flush_pend <= (r_state == S_WAIT) && !w_lat_done &&
                            (r_flush_pend || bus.flush);
        end
    end

    // Word assembly: capture bytes into lanes, publish byte count on HOLD entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_bytes <= '0;
        end else if (w_handshake) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_bytes <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_word[8*i +: 8] <= bus.fifo_data;
                end
            end
            r_idx <= w_idx_inc;
            if (w_capture_to_hold) begin
                r_bytes <= w_idx_inc;
            end
        end else if (w_fill_flush) begin
            r_bytes <= r_idx;
        end
    end

    // Reset gates the read strobe so no byte leaves the FIFO during reset.
    assign bus.fifo_rd    = w_issue_rd && !reset;
    assign bus.word_valid = (r_state == S_HOLD);
    assign bus.word_out   = r_word;
    assign bus.word_bytes = r_bytes;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a queue-based FIFO model, a byte-grouping
// reference model feeding an expected-word queue, directed scenarios and a
// randomized phase. Build with FIFO_WORD_PACKER_TIMEOUT_EN to cover auto-flush.
module tb_fifo_word_packer;
    localparam int BPW = 4;
    localparam int BW  = $clog2(BPW + 1);
    localparam int WW  = 8 * BPW;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    fifo_word_packer_if #(.BYTES_PER_WORD(BPW)) bus ();

    fifo_word_packer #(
        .BYTES_PER_WORD (BPW),
        .RD_LATENCY     (1),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- FIFO model (1-cycle read latency) ----------------
    logic [7:0] fifo_q[$];
    int         pushed_cnt = 0;
    int         popped_cnt = 0;

    assign bus.fifo_empty = (pushed_cnt == popped_cnt);

    initial bus.fifo_data = 8'h00;
    always @(posedge clk) begin
        if (bus.fifo_rd) begin
            bus.fifo_data <= fifo_q.pop_front();
            popped_cnt    <= popped_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    // Bytes accumulate in arrival order; a word is emitted when BPW bytes are
    // present or on flush with at least one byte. Entry = {bytes, word}.
    logic [7:0]       model_bytes[$];
    logic [BW+WW-1:0] exp_q[$];

    task automatic model_emit();
        logic [WW-1:0] w;
        if (model_bytes.size() > 0) begin
            w = '0;
            for (int i = 0; i < model_bytes.size(); i++) w[8*i +: 8] = model_bytes[i];
            exp_q.push_back({BW'(model_bytes.size()), w});
            model_bytes.delete();
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        model_bytes.push_back(b);
        if (model_bytes.size() == BPW) model_emit();
    endtask

    // ---------------- drivers ----------------
    bit ready_rand  = 1'b0;
    bit ready_fixed = 1'b1;

    initial begin
        bus.word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.word_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit to_model);
        fifo_q.push_back(b);
        pushed_cnt++;
        if (to_model) model_push(b);
    endtask

    task automatic flush_pulse();
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        model_emit();
    endtask

    task automatic wait_reads(input string tag);
        int i = 0;
        while (popped_cnt != pushed_cnt && i < 500) begin
            step(1);
            i++;
        end
        check(tag, 64'(popped_cnt), 64'(pushed_cnt));
    endtask

    task automatic wait_drain(input string tag);
        int i = 0;
        while ((exp_q.size() != 0 || popped_cnt != pushed_cnt) && i < 3000) begin
            step(1);
            i++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int               rd_cyc_q[$];
    int               valid_run      = 0;
    int               last_valid_run = 0;
    int               valid_cycles   = 0;
    int               valid_rise_cyc = -1;
    logic [BW+WW-1:0] held;
    logic [BW+WW-1:0] exp_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.fifo_rd) begin
                rd_cyc_q.push_back(cyc);
                check("rd_while_empty", 64'(bus.fifo_empty), 64'd0);
                check("rd_while_valid", 64'(bus.word_valid), 64'd0);
            end
            if (bus.word_valid) begin
                valid_cycles++;
                valid_run++;
                if (valid_run == 1) valid_rise_cyc = cyc;
                if (valid_run > 1) check("hold_stable", 64'({bus.word_bytes, bus.word_out}), 64'(held));
                held = {bus.word_bytes, bus.word_out};
                if (bus.word_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word_bytes", 64'(bus.word_bytes), 64'd0);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("word_out", 64'(bus.word_out), 64'(exp_e[WW-1:0]));
                        check("word_bytes", 64'(bus.word_bytes), 64'(exp_e[BW+WW-1:WW]));
                    end
                    last_valid_run = valid_run;
                    valid_run      = 0;
                end
            end
        end else begin
            valid_run = 0;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int v0;
        int n;

        bus.flush = 1'b0;
        reset     = 1'b1;
        step(3);
        check("rst_word_valid", 64'(bus.word_valid), 64'd0);
        check("rst_word_out", 64'(bus.word_out), 64'd0);
        check("rst_word_bytes", 64'(bus.word_bytes), 64'd0);
        check("rst_fifo_rd", 64'(bus.fifo_rd), 64'd0);
        reset = 1'b0;
        step(1);

        // 1: one full word, reads two cycles apart, valid for one cycle
        rd_cyc_q.delete();
        push_byte(8'h11, 1); push_byte(8'h22, 1); push_byte(8'h33, 1); push_byte(8'h44, 1);
        wait_drain("t1_drain");
        check("t1_rd_count", 64'(rd_cyc_q.size()), 64'd4);
        for (int k = 1; k < rd_cyc_q.size(); k++)
            check("t1_rd_spacing", 64'(rd_cyc_q[k] - rd_cyc_q[k-1]), 64'd2);
        check("t1_valid_len", 64'(last_valid_run), 64'd1);

        // 2: two bytes, FIFO runs empty, flush emits a 2-byte word
        push_byte(8'hA1, 1); push_byte(8'hB2, 1);
        wait_reads("t2_reads");
        step(3);
        check("t2_no_early_valid", 64'(bus.word_valid), 64'd0);
        flush_pulse();
        wait_drain("t2_drain");

        // 3: consumer stalls; only one word's worth of reads during the stall
        ready_fixed = 1'b0;
        base = popped_cnt;
        for (int k = 1; k <= 8; k++) push_byte(8'(k), 1);
        for (int i = 0; i < 100 && !bus.word_valid; i++) step(1);
        check("t3_valid_up", 64'(bus.word_valid), 64'd1);
        step(10);
        check("t3_reads_in_stall", 64'(popped_cnt - base), 64'd4);
        check("t3_held_word", 64'(bus.word_out), 64'h04030201);
        ready_fixed = 1'b1;
        wait_drain("t3_drain");

        // 4: flush lands while the third byte is in flight
        push_byte(8'hAA, 1); push_byte(8'hBB, 1); push_byte(8'hCC, 1);
        wait_reads("t4_reads");
        flush_pulse();
        wait_drain("t4_drain");

        // 5: reset with two bytes captured and a third in flight
        push_byte(8'hD1, 0); push_byte(8'hD2, 0); push_byte(8'hD3, 0);
        wait_reads("t5_reads");
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_word_out", 64'(bus.word_out), 64'd0);
        check("t5_rst_word_valid", 64'(bus.word_valid), 64'd0);
        check("t5_rst_word_bytes", 64'(bus.word_bytes), 64'd0);
        push_byte(8'hE1, 1);
        #1;
        check("t5_rst_no_rd", 64'(bus.fifo_rd), 64'd0);
        step(2);
        check("t5_rst_no_rd_later", 64'(bus.fifo_rd), 64'd0);
        reset = 1'b0;
        push_byte(8'hE2, 1); push_byte(8'hE3, 1); push_byte(8'hE4, 1);
        wait_drain("t5_drain");

        // 6: a lone byte with the FIFO left empty
        rd_cyc_q.delete();
        push_byte(8'h5A, 1);
        wait_reads("t6_reads");
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
        valid_rise_cyc = -1;
        model_emit();
        for (int i = 0; i < 60 && valid_rise_cyc < 0; i++) step(1);
        // read strobe cycle, +1 edge into WAIT, +1 latency to capture, +TMO idle
        check("t6_timeout_latency", 64'(valid_rise_cyc - rd_cyc_q[0]), 64'(2 + TMO));
        wait_drain("t6_drain");
`else
        v0 = valid_cycles;
        step(40);
        check("t6_no_autoflush", 64'(valid_cycles - v0), 64'd0);
        flush_pulse();
        wait_drain("t6_drain");
`endif

        // flush with nothing captured must not produce a word
        v0 = valid_cycles;
        flush_pulse();
        step(5);
        check("empty_flush_ignored", 64'(valid_cycles - v0), 64'd0);

        // randomized: bursts, gaps, flushes, random consumer back-pressure
        ready_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) begin
                push_byte(8'($urandom_range(0, 255)), 1);
                step($urandom_range(0, 3));
            end
            if ($urandom_range(0, 2) == 0) begin
                wait_reads("rnd_reads");
                flush_pulse();
            end
        end
        wait_reads("rnd_final_reads");
        flush_pulse();
        ready_rand = 1'b0;
        ready_fixed = 1'b1;
        wait_drain("rnd_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
